// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ sources,
// with a registered write command stage and a saturating contention counter.
// Optional: define REG_WRITE_ZERO_REG_EN to make register 0 a hardwired-zero sink.
module reg_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 3,
    parameter int CNT_W   = 8,
    localparam int SRC_W  = $clog2(NUM_REQ),
    localparam int NREG   = 2 ** ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [NREG-1:0]           wr_sel,
    output logic [SRC_W-1:0]          wr_src,
    output logic [CNT_W-1:0]          conflict_count
);

    localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W + 1)'(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_REQ  = SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [SRC_W-1:0]  rrPtr_q, rrPtr_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic [NREG-1:0]   wrSel_q, wrSel_d;
    logic [SRC_W-1:0]  wrSrc_q, wrSrc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] reqAddr [NUM_REQ];
    logic [DATA_W-1:0] reqData [NUM_REQ];
    logic              grantFound;
    logic [SRC_W-1:0]  grantIdx;
    logic              multiReq;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqAddr[i] = req_addr[i*ADDR_W +: ADDR_W];
            reqData[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts at rrPtr_q and wraps modulo NUM_REQ; first valid requester wins.
    always_comb begin : grantSearch
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        grantFound = 1'b0;
        grantIdx   = '0;
        req_ready  = '0;
        sum        = '0;
        idx        = '0;
        if (!reset && !stall) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                sum = {1'b0, rrPtr_q} + (SRC_W + 1)'(j);
                if (sum >= NUM_REQ_W) begin
                    sum = sum - NUM_REQ_W;
                end
                idx = SRC_W'(sum);
                if (!grantFound && req_valid[idx]) begin
                    grantFound = 1'b1;
                    grantIdx   = idx;
                end
            end
            if (grantFound) begin
                req_ready[grantIdx] = 1'b1;
            end
        end
    end

    assign multiReq = ($countones(req_valid) > 1);

    always_comb begin
        rrPtr_d  = rrPtr_q;
        wrEn_d   = 1'b0;
        wrSel_d  = '0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        wrSrc_d  = wrSrc_q;
        cnt_d    = cnt_q;
        if (grantFound) begin
            wrAddr_d = reqAddr[grantIdx];
            wrData_d = reqData[grantIdx];
            wrSrc_d  = grantIdx;
            rrPtr_d  = (grantIdx == LAST_REQ) ? '0 : grantIdx + 1'b1;
`ifdef REG_WRITE_ZERO_REG_EN
            wrEn_d   = (reqAddr[grantIdx] != '0);
`else
            wrEn_d   = 1'b1;
`endif
            if (wrEn_d) begin
                wrSel_d = NREG'(1'b1) << reqAddr[grantIdx];
            end
        end
        // A stalled cycle is not contention: the port is busy, not disputed.
        if (!stall && multiReq && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr_q  <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            wrSel_q  <= '0;
            wrSrc_q  <= '0;
            cnt_q    <= '0;
        end else begin
            rrPtr_q  <= rrPtr_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
            wrSel_q  <= wrSel_d;
            wrSrc_q  <= wrSrc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_en          = wrEn_q;
    assign wr_addr        = wrAddr_q;
    assign wr_data        = wrData_q;
    assign wr_sel         = wrSel_q;
    assign wr_src         = wrSrc_q;
    assign conflict_count = cnt_q;

endmodule
